// File: rtl/shift8_pkg.sv
// rtl/shift8_pkg.sv - shared width, state encoding and counter sizing for the shift8 receiver
package shift8_pkg;

    localparam int SHIFT8_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    // Counter must reach WIDTH when the parity slot is present.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int SHIFT8_CNT_W = cnt_width(SHIFT8_WIDTH);

endpackage

// File: rtl/shift8_rx_hold.sv
// rtl/shift8_rx_hold.sv - holding register, vld/rdy handshake, overflow flag and tri-state bus driver
// Optional parity status under SHIFT8_RX_PARITY_EN.
module shift8_rx_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             done,
    input  logic [WIDTH-1:0] cand,
`ifdef SHIFT8_RX_PARITY_EN
    input  logic             cand_perr,
    output logic             perr,
`endif
    input  logic             rdy,
    input  logic             oe,
    inout  wire  [WIDTH-1:0] data,
    output logic             vld,
    output logic             ovf
);

    logic [WIDTH-1:0] hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
            vld  <= 1'b0;
            ovf  <= 1'b0;
`ifdef SHIFT8_RX_PARITY_EN
            perr <= 1'b0;
`endif
        end else begin
            if (done) begin
                // A consumer taking the old byte on this edge frees the slot for the new one.
                if (!vld || rdy) begin
                    hold <= cand;
                    vld  <= 1'b1;
`ifdef SHIFT8_RX_PARITY_EN
                    perr <= cand_perr;
`endif
                end else begin
                    ovf <= 1'b1;
                end
            end else if (vld && rdy) begin
                vld <= 1'b0;
            end
            if (clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign data = (oe && vld) ? hold : {WIDTH{1'bz}};

endmodule

// File: rtl/shift8_rx.sv
// rtl/shift8_rx.sv - LSB-first serial-to-parallel receiver: shifter, bit counter and framing FSM
// Define SHIFT8_RX_PARITY_EN to append an even-parity bit to each frame and expose perr.
module shift8_rx
    import shift8_pkg::*;
#(
    parameter int WIDTH = SHIFT8_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sen,
    input  logic             clr,
    input  logic             rdy,
    input  logic             oe,
    inout  wire  [WIDTH-1:0] data,
    output logic             vld,
    output logic             busy,
`ifdef SHIFT8_RX_PARITY_EN
    output logic             perr,
`endif
    output logic             ovf
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shifted;
    logic             done;
    logic [WIDTH-1:0] cand;

`ifdef SHIFT8_RX_PARITY_EN
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic             cand_perr;

    assign shifted = {sin, sh[WIDTH-1:1]};
    assign sh_next = shifted;

    always_comb begin
        done      = sen && !clr && (state == PAR);
        cand      = sh;
        cand_perr = (^sh) ^ sin;
    end
`else
    // Bit 0 would only ever be shifted out on the completing strobe, so it is never stored.
    logic [WIDTH-1:1] sh;
    logic [WIDTH-1:1] sh_next;

    assign shifted = {sin, sh};
    assign sh_next = shifted[WIDTH-1:1];

    always_comb begin
        done = sen && !clr && (state == SHIFT) && (cnt == LAST);
        cand = shifted;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            busy  <= 1'b0;
        end else if (clr) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (sen) begin
            case (state)
                IDLE: begin
                    sh    <= sh_next;
                    cnt   <= CW'(1);
                    state <= SHIFT;
                    busy  <= 1'b1;
                end
                SHIFT: begin
                    sh <= sh_next;
                    if (cnt == LAST) begin
`ifdef SHIFT8_RX_PARITY_EN
                        state <= PAR;
                        cnt   <= cnt + CW'(1);
`else
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    shift8_rx_hold #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .done     (done),
        .cand     (cand),
`ifdef SHIFT8_RX_PARITY_EN
        .cand_perr(cand_perr),
        .perr     (perr),
`endif
        .rdy      (rdy),
        .oe       (oe),
        .data     (data),
        .vld      (vld),
        .ovf      (ovf)
    );

endmodule

// File: tb/tb_shift8_rx.sv
// tb/tb_shift8_rx.sv - directed self-checking bench for shift8_rx
// Parity vectors run only when SHIFT8_RX_PARITY_EN is defined.
module tb_shift8_rx;

`ifdef SHIFT8_RX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst, sin, sen, clr, rdy, oe;
    wire  [7:0] data;
    logic       vld, busy, ovf;
`ifdef SHIFT8_RX_PARITY_EN
    logic       perr;
`endif
    logic       probe_en;
    logic [7:0] probe_val;
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] frames [4];

    always #5 clk = ~clk;

    assign data = probe_en ? probe_val : 8'bz;

    shift8_rx dut (
        .clk (clk),
        .rst (rst),
        .sin (sin),
        .sen (sen),
        .clr (clr),
        .rdy (rdy),
        .oe  (oe),
        .data(data),
        .vld (vld),
        .busy(busy),
`ifdef SHIFT8_RX_PARITY_EN
        .perr(perr),
`endif
        .ovf (ovf)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] v, input int i);
        return (i < 8) ? v[i] : ^v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sen = 1'b1;
        sin = b;
        tick();
        sen = 1'b0;
    endtask

    task automatic send_range(input logic [7:0] v, input int from, input int to);
        for (int i = from; i < to; i++) send_bit(frame_bit(v, i));
    endtask

    task automatic send_frame(input logic [7:0] v, input logic rdy_last);
        send_range(v, 0, NB - 1);
        rdy = rdy_last;
        send_bit(frame_bit(v, NB - 1));
        rdy = 1'b0;
    endtask

    task automatic consume();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("consume_vld", {7'd0, vld}, 8'h00);
    endtask

    task automatic probe_z(input string tag);
        probe_en  = 1'b1;
        probe_val = 8'h5A;
        #1;
        chk(tag, data, 8'h5A);
        probe_en  = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; sin = 1'b0; sen = 1'b0; clr = 1'b0; rdy = 1'b0; oe = 1'b1;
        probe_en = 1'b0; probe_val = 8'h00;
        tick(); tick();
        chk("reset_vld",  {7'd0, vld},  8'h00);
        chk("reset_busy", {7'd0, busy}, 8'h00);
        chk("reset_ovf",  {7'd0, ovf},  8'h00);
        probe_z("reset_data_z");

        // reset mid-frame discards the partial frame
        rst = 1'b0;
        send_range(8'h07, 0, 3);
        chk("partial_busy", {7'd0, busy}, 8'h01);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("midrst_vld",  {7'd0, vld},  8'h00);
        chk("midrst_busy", {7'd0, busy}, 8'h00);
        chk("midrst_ovf",  {7'd0, ovf},  8'h00);
        probe_z("midrst_data_z");

        send_range(8'hA5, 0, NB - 1);
        chk("a5_pre_vld",  {7'd0, vld},  8'h00);
        chk("a5_pre_busy", {7'd0, busy}, 8'h01);
        send_bit(frame_bit(8'hA5, NB - 1));
        chk("a5_vld",  {7'd0, vld},  8'h01);
        chk("a5_busy", {7'd0, busy}, 8'h00);
        chk("a5_data", data, 8'hA5);
        oe = 1'b0;
        probe_z("a5_oe0_z");
        oe = 1'b1;
        consume();
        probe_z("empty_data_z");

        // overflow drops the second byte
        send_frame(8'h3C, 1'b0);
        send_frame(8'hC3, 1'b0);
        chk("ovf_vld",  {7'd0, vld}, 8'h01);
        chk("ovf_flag", {7'd0, ovf}, 8'h01);
        chk("ovf_hold", data, 8'h3C);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovf",  {7'd0, ovf}, 8'h00);
        chk("clr_vld",  {7'd0, vld}, 8'h01);
        chk("clr_hold", data, 8'h3C);
        consume();

        send_frame(8'h3C, 1'b0);
        send_frame(8'hC3, 1'b1);
        chk("swap_vld",  {7'd0, vld}, 8'h01);
        chk("swap_ovf",  {7'd0, ovf}, 8'h00);
        chk("swap_hold", data, 8'hC3);
        consume();

        // clr aborts, then gapped strobes
        send_range(8'h03, 0, 3);
        chk("abort_busy_pre", {7'd0, busy}, 8'h01);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("abort_busy", {7'd0, busy}, 8'h00);
        for (int i = 0; i < NB; i++) begin
            send_bit(frame_bit(8'hFF, i));
            repeat (i % 3) tick();
        end
        chk("gap_vld",  {7'd0, vld},  8'h01);
        chk("gap_data", data, 8'hFF);
        chk("gap_busy", {7'd0, busy}, 8'h00);
        consume();

        // clr coincident with sen discards that bit
        clr = 1'b1; sen = 1'b1; sin = 1'b1;
        tick();
        clr = 1'b0; sen = 1'b0;
        chk("clrsen_idle_busy", {7'd0, busy}, 8'h00);
        send_range(8'h96, 0, 4);
        clr = 1'b1; sen = 1'b1; sin = 1'b1;
        tick();
        clr = 1'b0; sen = 1'b0;
        chk("clrsen_mid_busy", {7'd0, busy}, 8'h00);
        send_frame(8'h96, 1'b0);
        chk("clrsen_vld",  {7'd0, vld}, 8'h01);
        chk("clrsen_data", data, 8'h96);
        consume();

        // back-to-back frames with rdy held high
        frames[0] = 8'h01; frames[1] = 8'h80; frames[2] = 8'h55; frames[3] = 8'hAA;
        rdy = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NB; i++) begin
                sen = 1'b1;
                sin = frame_bit(frames[f], i);
                tick();
                chk($sformatf("b2b_vld_f%0d_b%0d", f, i), {7'd0, vld}, (i == NB - 1) ? 8'h01 : 8'h00);
                if (i == NB - 1) chk($sformatf("b2b_data_f%0d", f), data, frames[f]);
            end
        end
        sen = 1'b0;
        tick();
        rdy = 1'b0;
        chk("b2b_end_vld", {7'd0, vld}, 8'h00);
        chk("b2b_ovf",     {7'd0, ovf}, 8'h00);

`ifdef SHIFT8_RX_PARITY_EN
        send_range(8'h07, 0, 8);
        send_bit(1'b1);
        chk("par07_1_data", data, 8'h07);
        chk("par07_1_perr", {7'd0, perr}, 8'h00);
        consume();
        send_range(8'h07, 0, 8);
        send_bit(1'b0);
        chk("par07_0_perr", {7'd0, perr}, 8'h01);
        consume();
        send_range(8'h00, 0, 8);
        send_bit(1'b0);
        chk("par00_0_data", data, 8'h00);
        chk("par00_0_perr", {7'd0, perr}, 8'h00);
        consume();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift8_rx.md
# shift8_rx

Serial-to-parallel receiver: the reader for the 8-bit shift-register datapath's serial output stream. It samples an LSB-first bit stream under a bit strobe and assembles 8-bit frames. Each completed byte goes into a holding register with a valid/ready handshake and an optional tri-state drive onto the shared 8-bit data bus. It sits between a serial shifter's `qa` output and a parallel consumer such as a multiplier operand register or a bus master.

## Interface
- `WIDTH`, 8, data bits per frame; must be ≥ 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `sin`  in  1  serial data, LSB first.
- `sen`  in  1  bit strobe; `sin` is sampled on an edge where `sen`=1.
- `clr`  in  1  aborts the partial frame and clears `ovf`.
- `rdy`  in  1  consumer accepts the held byte (transfer when `vld & rdy`).
- `oe`  in  1  bus output enable.
- `data`  inout  WIDTH  driven with `hold` when `oe & vld`, otherwise high-Z.
- `vld`  out  1  holding register contains an unconsumed byte.
- `busy`  out  1  partial frame in progress (bit count ≠ 0).
- `ovf`  out  1  sticky: a completed byte was dropped.
- `perr`  out  1  parity error for the held byte; exists only when SHIFT8_RX_PARITY_EN is defined.

## Operation
- Shift register `sh[WIDTH-1:0]` shifts right on `sen`: `sh <= {sin, sh[WIDTH-1:1]}`. The first bit received ends up in bit 0.
- Bit counter `cnt` runs 0..WIDTH-1 (0..WIDTH with parity). It advances only when `sen`=1, so gaps between strobes are allowed.
- States:
  - IDLE (`cnt`=0) -> SHIFT on `sen`.
  - SHIFT -> completes on the `sen` that samples the last data bit.
  - With parity enabled: the last data bit moves to PAR instead, and PAR completes on the next `sen`.
  - Completion always returns to IDLE.
- On completion, the candidate byte is `{sin, sh[WIDTH-1:1]}` (or `sh` when the completing bit is parity).
  - `vld`=0, or `vld & rdy` in the same cycle: `hold` <= candidate, `vld` <= 1, no overflow.
  - `vld & !rdy`: candidate is dropped, `hold` is unchanged, `ovf` <= 1.
- Handshake with no completion that cycle: `vld & rdy` -> `vld` <= 0 on that edge. `rdy` while `vld`=0 is ignored.
- `clr`:
  - Forces `cnt` <= 0 and `ovf` <= 0.
  - Does not touch `hold`, `vld`, or `perr`.
  - `clr` with `sen` in the same cycle: `clr` wins and the bit is discarded.
- `rst`: `sh`, `cnt`, `hold` = 0; `vld`, `ovf`, `perr`, `busy` = 0; `data` high-Z. `rst` overrides all other inputs, including mid-frame.
- `data` is combinational from `hold`, `oe`, and `vld`. It never drives while `vld`=0.

## Timing
- `vld` rises on the edge that samples the final bit, so it is visible in the next cycle. Minimum latency from first bit to `vld`: WIDTH strobes (WIDTH+1 with parity).
- Back-to-back frames at full strobe rate are sustained without loss when `rdy`=1 continuously.
- `busy` and `ovf` are registered. `perr` is registered together with `hold` and is meaningful only while `vld`=1.

## Configuration
- `SHIFT8_RX_PARITY_EN` defined:
  - Each frame is WIDTH data bits followed by one even-parity bit.
  - `perr` <= (XOR of the data bits) ≠ (parity bit), loaded whenever `hold` loads.
  - Dropped frames do not update `perr`.
- `SHIFT8_RX_PARITY_EN` undefined: frames are WIDTH bits, the PAR state is absent, and the `perr` port is absent.

## Structure
- Shared package `shift8_pkg`:
  - `WIDTH` default constant.
  - State encoding typedef: IDLE, SHIFT, PAR.
  - Counter width constant.
- One sub-module, `shift8_rx_hold`: holding register, `vld`/`rdy` handshake, overflow flag, and tri-state `data` driver. The top level holds the shifter, counter, and FSM.

## Test plan
- `rst`=1 for 2 cycles mid-frame -> `vld`=`busy`=`ovf`=0, `data`=zz. Then 8 fresh bits assemble correctly, proving the partial frame was discarded.
- Bits 1,0,1,0,0,1,0,1 on consecutive `sen`, `rdy`=0, `oe`=1 -> `vld`=1 the cycle after the 8th bit and `data`=0xA5. With `oe`=0 -> `data`=zz.
- Send 0x3C with `rdy`=0, then 0xC3 with `rdy`=0 -> `hold`=0x3C, `ovf`=1. Repeat with `rdy` pulsed on the edge where 0xC3 completes -> `hold`=0xC3, `vld`=1, `ovf`=0.
- `clr` after 3 bits, then 8 ones with random gaps in `sen` -> byte 0xFF, `busy` low after completion. `clr` coincident with `sen` -> that bit is not counted.
- `rdy`=1 constantly, 4 back-to-back frames 0x01,0x80,0x55,0xAA -> each presented exactly once in order, `ovf`=0.
- Parity build: 0x07 + parity bit 1 -> `perr`=0. 0x07 + parity bit 0 -> `perr`=1. 0x00 + parity bit 0 -> `perr`=0.
